tlv493_mag_filter: RTL and testbench

- Downstream stage of the TLV493 sensor reader; consumes one sensor's raw 12-bit two's-complement mag_x/mag_y/mag_z samples, one strobe per completed I2C read.
- Applies a sliding boxcar average over 2^LOG2_WINDOW samples per axis, rejects samples flagged by an I2C ack error, and flags a stale sensor when samples stop arriving.
- Output feeds control/Avalon readout logic as filtered 12-bit values with a valid pulse.

---
 rtl/tlv493_mag_filter.sv | 122 ++++++++++++
 tb/tb_tlv493_mag_filter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlv493_mag_filter.sv
// TLV493 per-axis boxcar filter with ack-error rejection
// and stale-sensor detection.
module tlv493_mag_filter #(
  parameter int LOG2_WINDOW    = 3,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic        in_error,
  input  logic [11:0] mag_x,
  input  logic [11:0] mag_y,
  input  logic [11:0] mag_z,
  input  logic        flush,
  output logic [11:0] avg_x,
  output logic [11:0] avg_y,
  output logic [11:0] avg_z,
  output logic        out_valid,
  output logic        filled,
  output logic        stale,
  output logic [15:0] error_count
);

  localparam int N  = 1 << LOG2_WINDOW;
  localparam int SW = 12 + LOG2_WINDOW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LOG2_WINDOW:0] FULL = (LOG2_WINDOW + 1)'(N);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic                   accept;
  logic                   reject;
  logic                   full;
  logic                   pend;
  logic                   upd;
  logic [LOG2_WINDOW-1:0] ptr;
  logic [LOG2_WINDOW:0]   cnt;
  logic [TW-1:0]          tcnt;

  logic [11:0]   mag    [3];
  logic [11:0]   old    [3];
  logic [11:0]   avg    [3];
  logic [11:0]   win    [3][N];
  logic [SW-1:0] sum    [3];
  logic [SW-1:0] sum_nx [3];

  assign mag[0] = mag_x;
  assign mag[1] = mag_y;
  assign mag[2] = mag_z;

  assign accept = sample_valid & ~in_error & ~flush;
  assign reject = sample_valid & in_error & ~flush;
  assign full   = (cnt == FULL);
  assign upd    = pend & full & ~flush;

  // Evicted sample only subtracts once the window is full.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      old[i]    = full ? win[i][ptr] : '0;
      sum_nx[i] = sum[i]
                + {{LOG2_WINDOW{mag[i][11]}}, mag[i]}
                - {{LOG2_WINDOW{old[i][11]}}, old[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win[i][ptr] <= mag[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sum[i] <= '0;
        avg[i] <= '0;
      end
      ptr         <= '0;
      cnt         <= '0;
      pend        <= 1'b0;
      out_valid   <= 1'b0;
      tcnt        <= '0;
      error_count <= '0;
    end else begin
      pend      <= accept;
      out_valid <= upd;
      // Top bits of the sum are the floor-shifted mean.
      if (upd) begin
        for (int i = 0; i < 3; i++) begin
          avg[i] <= sum[i][SW-1:LOG2_WINDOW];
        end
      end
      if (flush) begin
        for (int i = 0; i < 3; i++) begin
          sum[i] <= '0;
        end
        ptr <= '0;
        cnt <= '0;
      end else if (accept) begin
        sum <= sum_nx;
        ptr <= ptr + 1'b1;
        if (!full) cnt <= cnt + 1'b1;
      end
      if (reject && error_count != 16'hFFFF) begin
        error_count <= error_count + 16'd1;
      end
      if (accept) begin
        tcnt <= '0;
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign avg_x  = avg[0];
  assign avg_y  = avg[1];
  assign avg_z  = avg[2];
  assign filled = full;
  assign stale  = (tcnt == TMAX);

endmodule

// File: tb/tb_tlv493_mag_filter.sv
// Randomized and directed check of tlv493_mag_filter
// against a queue-based window model.
module tb_tlv493_mag_filter;

  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic        in_error = 1'b0;
  logic [11:0] mag_x = '0;
  logic [11:0] mag_y = '0;
  logic [11:0] mag_z = '0;
  logic        flush = 1'b0;
  logic [11:0] avg_x;
  logic [11:0] avg_y;
  logic [11:0] avg_z;
  logic        out_valid;
  logic        filled;
  logic        stale;
  logic [15:0] error_count;

  tlv493_mag_filter #(
    .LOG2_WINDOW(L),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sample_valid(sample_valid),
    .in_error(in_error),
    .mag_x(mag_x),
    .mag_y(mag_y),
    .mag_z(mag_z),
    .flush(flush),
    .avg_x(avg_x),
    .avg_y(avg_y),
    .avg_z(avg_z),
    .out_valid(out_valid),
    .filled(filled),
    .stale(stale),
    .error_count(error_count)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  // Model state
  int          win [3][$];
  logic [11:0] e_avg [3];
  logic [11:0] p_avg [3];
  bit          p_v;
  bit          e_ov;
  bit          e_filled;
  bit          e_stale;
  int          idle;
  int          e_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [11:0] v);
    return v[11] ? int'(v) - 4096 : int'(v);
  endfunction

  // Mean rounded toward minus infinity
  function automatic logic [11:0] favg(input int s);
    int q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return 12'(q);
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("avg_x", 32'(avg_x), 32'(e_avg[0]));
    chk("avg_y", 32'(avg_y), 32'(e_avg[1]));
    chk("avg_z", 32'(avg_z), 32'(e_avg[2]));
    chk("filled", 32'(filled), 32'(e_filled));
    chk("stale", 32'(stale), 32'(e_stale));
    chk("error_count", 32'(error_count), 32'(e_err));
  endtask

  task automatic cyc(input bit sv, input bit er,
                     input logic [11:0] x,
                     input logic [11:0] y,
                     input logic [11:0] z,
                     input bit fl);
    bit acc;
    bit rej;
    int s;
    logic [11:0] m [3];
    m[0] = x;
    m[1] = y;
    m[2] = z;
    sample_valid = sv;
    in_error = er;
    mag_x = x;
    mag_y = y;
    mag_z = z;
    flush = fl;
    acc = sv && !er && !fl;
    rej = sv && er && !fl;
    e_ov = p_v && !fl;
    if (e_ov) e_avg = p_avg;
    p_v = 1'b0;
    if (fl) begin
      for (int i = 0; i < 3; i++) win[i].delete();
    end else if (acc) begin
      for (int i = 0; i < 3; i++) begin
        win[i].push_back(sx(m[i]));
        if (win[i].size() > N) void'(win[i].pop_front());
      end
      if (win[0].size() == N) begin
        p_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
          s = 0;
          foreach (win[i][k]) s += win[i][k];
          p_avg[i] = favg(s);
        end
      end
    end
    e_filled = (win[0].size() == N);
    if (acc) idle = 0;
    else if (idle < TO) idle++;
    e_stale = (idle == TO);
    if (rej && e_err < 65535) e_err++;
    @(negedge clock);
    check_all();
  endtask

  task automatic acc_x(input logic [11:0] x);
    cyc(1'b1, 1'b0, x, 12'(x + 12'd1), 12'(~x), 1'b0);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      e_avg[i] = '0;
      p_avg[i] = '0;
    end
    p_v = 0; e_ov = 0; e_filled = 0;
    e_stale = 0; idle = 0; e_err = 0;

    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();

    // Fill a window of four
    acc_x(12'd4);
    acc_x(12'd8);
    acc_x(12'd12);
    acc_x(12'd16);
    chk("no_ov_before_lat", 32'(out_valid), 32'd0);
    idle_cyc();
    chk("ov_full", 32'(out_valid), 32'd1);
    chk("avg10", 32'(avg_x), 32'd10);
    chk("filled_full", 32'(filled), 32'd1);

    acc_x(12'd20);
    idle_cyc();
    chk("avg14", 32'(avg_x), 32'd14);

    // Signed extreme, back to back
    repeat (4) acc_x(12'h800);
    idle_cyc();
    chk("avg_min", 32'(avg_x), 32'h800);

    acc_x(12'hFFF);
    acc_x(12'hFFE);
    acc_x(12'hFFD);
    acc_x(12'hFFC);
    idle_cyc();
    chk("avg_neg_floor", 32'(avg_x), 32'hFFD);

    // Rejected sample leaves averages alone
    cyc(1'b1, 1'b1, 12'h7FF, 12'h7FF, 12'h7FF, 1'b0);
    idle_cyc();
    chk("rej_no_ov", 32'(out_valid), 32'd0);
    chk("rej_avg", 32'(avg_x), 32'hFFD);
    chk("err_one", 32'(error_count), 32'd1);

    // Saturation; rejects also let the timeout run out
    repeat (65537) cyc(1'b1, 1'b1, 12'h123, 12'h456, 12'h789, 1'b0);
    chk("err_sat", 32'(error_count), 32'hFFFF);
    chk("stale_on_rej", 32'(stale), 32'd1);
    acc_x(12'd5);
    chk("stale_clear", 32'(stale), 32'd0);

    // Fresh idle run to the exact timeout boundary
    repeat (TO - 1) idle_cyc();
    chk("stale_pre", 32'(stale), 32'd0);
    idle_cyc();
    chk("stale_at_to", 32'(stale), 32'd1);

    // Flush cancels a pending update and drops the sample
    repeat (4) acc_x(12'd9);
    idle_cyc();
    acc_x(12'd100);
    cyc(1'b1, 1'b0, 12'd50, 12'd50, 12'd50, 1'b1);
    chk("flush_no_ov", 32'(out_valid), 32'd0);
    chk("flush_filled", 32'(filled), 32'd0);
    chk("flush_avg_hold", 32'(avg_x), 32'd9);
    repeat (4) acc_x(12'd7);
    idle_cyc();
    chk("avg7", 32'(avg_x), 32'd7);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] rx;
      logic [11:0] ry;
      logic [11:0] rz;
      rx = 12'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom);
      rz = ($urandom_range(0, 7) == 0) ? 12'h7FF : 12'($urandom);
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0,
          rx, ry, rz,
          $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
